// File: rtl/rob_cpl_arb.sv
// rob_cpl_arb: per-EU 2-deep completion buffers arbitrated round-robin onto four ROB busy-clear ports
module rob_cpl_arb #(
    parameter int NREQ       = 6,
    parameter int WIDTH_BANK = 3,
    parameter int WIDTH_BRM  = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NREQ-1:0]                i_valid,
    output logic [NREQ-1:0]                o_ready,
    input  logic [NREQ*(WIDTH_BANK+2)-1:0] i_tag,
    input  logic [NREQ*WIDTH_BRM-1:0]      i_brmask,
    input  logic [WIDTH_BRM:0]             i_kill,
    output logic [WIDTH_BANK+2:0]          o_rst_busy0,
    output logic [WIDTH_BANK+2:0]          o_rst_busy1,
    output logic [WIDTH_BANK+2:0]          o_rst_busy2,
    output logic [WIDTH_BANK+2:0]          o_rst_busy3,
    output logic                           o_idle
);
    localparam int WT = WIDTH_BANK + 2;
    localparam int WE = WT + WIDTH_BRM;
    localparam int WP = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NP = 4;

    // An entry is younger than the killing branch when its tag lies 1..half-range ahead of the kill mask
    function automatic logic f_killed(input logic [WIDTH_BRM:0] kill, input logic [WIDTH_BRM-1:0] bm);
        logic [WIDTH_BRM-1:0] d;
        d = bm - kill[WIDTH_BRM-1:0];
        return kill[WIDTH_BRM] && (d != '0) && ({1'b0, d} <= ((WIDTH_BRM+1)'(1) << (WIDTH_BRM-1)));
    endfunction

    logic [WE-1:0]   r_ent0 [NREQ];
    logic [WE-1:0]   r_ent1 [NREQ];
    logic [1:0]      r_cnt  [NREQ];
    logic [WP-1:0]   r_rr;
    logic [WT:0]     r_busy [NP];
    logic [WE-1:0]   w_nxt0 [NREQ];
    logic [WE-1:0]   w_nxt1 [NREQ];
    logic [1:0]      w_ncnt [NREQ];
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_nz;
    logic [NP-1:0]   w_pv;
    logic [WP-1:0]   w_pi   [NP];
    logic [WT-1:0]   w_tag  [NP];
    logic [WP-1:0]   w_last;

    for (genvar k = 0; k < NREQ; k++) begin : g_req
        logic [WE-1:0] w_in;
        logic          w_k0;
        logic          w_k1;
        logic          w_push;
        assign w_in       = {i_tag[k*WT +: WT], i_brmask[k*WIDTH_BRM +: WIDTH_BRM]};
        assign w_nz[k]    = r_cnt[k] != 2'd0;
        assign o_ready[k] = r_cnt[k] < 2'd2;
        assign w_elig[k]  = w_nz[k] && !f_killed(i_kill, r_ent0[k][WIDTH_BRM-1:0]);
        assign w_k0       = w_elig[k] && !w_gnt[k];
        assign w_k1       = (r_cnt[k] == 2'd2) && !f_killed(i_kill, r_ent1[k][WIDTH_BRM-1:0]);
        assign w_push     = i_valid[k] && o_ready[k] && !f_killed(i_kill, w_in[WIDTH_BRM-1:0]);
        assign w_nxt0[k]  = w_k0 ? r_ent0[k] : (w_k1 ? r_ent1[k] : w_in);
        assign w_nxt1[k]  = (w_k0 && w_k1) ? r_ent1[k] : w_in;
        assign w_ncnt[k]  = 2'(w_k0) + 2'(w_k1) + 2'(w_push);
    end

    for (genvar p = 0; p < NP; p++) begin : g_port
        assign w_tag[p] = r_ent0[w_pi[p]][WE-1:WIDTH_BRM];
    end

    // Scan requesters from r_rr and hand the first four eligible heads to ports 0..3 in scan order
    always_comb begin
        int idx;
        int n;
        w_gnt  = '0;
        w_pv   = '0;
        w_last = r_rr;
        n      = 0;
        for (int p = 0; p < NP; p++) w_pi[p] = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(r_rr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (w_elig[idx] && n < NP) begin
                w_gnt[idx] = 1'b1;
                w_pv[n]    = 1'b1;
                w_pi[n]    = WP'(idx);
                w_last     = WP'(idx);
                n          = n + 1;
            end
        end
    end

    // Buffer contents, round-robin pointer and registered busy-clear ports
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr <= '0;
            for (int j = 0; j < NREQ; j++) begin
                r_cnt[j]  <= '0;
                r_ent0[j] <= '0;
                r_ent1[j] <= '0;
            end
            for (int p = 0; p < NP; p++) r_busy[p] <= '0;
        end else begin
            if (|w_gnt) r_rr <= (w_last == WP'(NREQ - 1)) ? '0 : w_last + WP'(1);
            for (int j = 0; j < NREQ; j++) begin
                r_cnt[j]  <= w_ncnt[j];
                r_ent0[j] <= w_nxt0[j];
                r_ent1[j] <= w_nxt1[j];
            end
            for (int p = 0; p < NP; p++) r_busy[p] <= w_pv[p] ? {1'b1, w_tag[p]} : '0;
        end
    end

    assign o_rst_busy0 = r_busy[0];
    assign o_rst_busy1 = r_busy[1];
    assign o_rst_busy2 = r_busy[2];
    assign o_rst_busy3 = r_busy[3];
    assign o_idle      = ~|w_nz;
endmodule

// File: tb/tb_rob_cpl_arb.sv
// tb_rob_cpl_arb: directed scenarios with a per-cycle queue of expected busy-clear port words
module tb_rob_cpl_arb;
    logic        i_clk;
    logic        i_rst_n;
    logic [5:0]  i_valid;
    logic [5:0]  o_ready;
    logic [29:0] i_tag;
    logic [23:0] i_brmask;
    logic [4:0]  i_kill;
    logic [5:0]  o_rst_busy0;
    logic [5:0]  o_rst_busy1;
    logic [5:0]  o_rst_busy2;
    logic [5:0]  o_rst_busy3;
    logic        o_idle;
    logic [23:0] obs;
    logic [23:0] exp_q [$];
    int          n_vec;
    int          n_err;

    rob_cpl_arb #(.NREQ(6), .WIDTH_BANK(3), .WIDTH_BRM(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_tag(i_tag), .i_brmask(i_brmask), .i_kill(i_kill),
        .o_rst_busy0(o_rst_busy0), .o_rst_busy1(o_rst_busy1),
        .o_rst_busy2(o_rst_busy2), .o_rst_busy3(o_rst_busy3), .o_idle(o_idle)
    );

    assign obs = {o_rst_busy3, o_rst_busy2, o_rst_busy1, o_rst_busy0};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [5:0] g(input logic [4:0] t);
        return {1'b1, t};
    endfunction

    task automatic cyc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [4:0] t, input logic [3:0] bm);
        i_valid[k] = 1'b1;
        i_tag[k*5 +: 5] = t;
        i_brmask[k*4 +: 4] = bm;
    endtask

    task automatic do_reset;
        i_valid = '0;
        i_kill  = '0;
        i_rst_n = 1'b0;
        #2;
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [23:0] e;
        i_rst_n = 1'b0;
        #3;
        n_vec++; if (o_ready !== 6'h3f) begin n_err++; $display("FAIL reset_ready got=%h want=3f", o_ready); end
        n_vec++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%b want=1", o_idle); end
        n_vec++; if (obs !== 24'd0) begin n_err++; $display("FAIL reset_ports got=%h want=0", obs); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        exp_q.push_back(24'd0); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL reset_after got=%h want=%h", obs, e); end
        n_vec++; if (o_ready !== 6'h3f || o_idle !== 1'b1) begin n_err++; $display("FAIL reset_after_rdy got=%h/%b want=3f/1", o_ready, o_idle); end
    endtask

    task automatic test_single;
        logic [23:0] e;
        do_reset();
        set_req(2, {3'd5, 2'd1}, 4'd0);
        exp_q.push_back(24'd0); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL single_accept got=%h want=%h", obs, e); end
        n_vec++; if (o_idle !== 1'b0) begin n_err++; $display("FAIL single_busy_idle got=%b want=0", o_idle); end
        exp_q.push_back({18'd0, 6'h35}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL single_grant got=%h want=%h", obs, e); end
        n_vec++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL single_idle got=%b want=1", o_idle); end
        exp_q.push_back(24'd0); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL single_clear got=%h want=%h", obs, e); end
    endtask

    task automatic test_oversub;
        logic [23:0] e;
        do_reset();
        for (int k = 0; k < 6; k++) set_req(k, 5'(8 + k), 4'd0);
        exp_q.push_back(24'd0); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL oversub_accept got=%h want=%h", obs, e); end
        exp_q.push_back({g(11), g(10), g(9), g(8)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL oversub_cycA got=%h want=%h", obs, e); end
        exp_q.push_back({12'd0, g(13), g(12)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL oversub_cycB got=%h want=%h", obs, e); end
        n_vec++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL oversub_idle got=%b want=1", o_idle); end
        set_req(1, 5'd1, 4'd0);
        set_req(0, 5'd2, 4'd0);
        exp_q.push_back(24'd0); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL oversub_rr_accept got=%h want=%h", obs, e); end
        exp_q.push_back({12'd0, g(1), g(2)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL oversub_rr_wrap got=%h want=%h", obs, e); end
    endtask

    task automatic test_backpressure;
        logic [23:0] e;
        do_reset();
        set_req(0, 5'd30, 4'd0);
        exp_q.push_back(24'd0); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL bp_pre_accept got=%h want=%h", obs, e); end
        exp_q.push_back({18'd0, g(30)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL bp_pre_grant got=%h want=%h", obs, e); end
        set_req(0, 5'd16, 4'd0);
        for (int k = 1; k < 6; k++) set_req(k, 5'(k), 4'd0);
        exp_q.push_back(24'd0); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL bp_c0 got=%h want=%h", obs, e); end
        set_req(0, 5'd17, 4'd0);
        for (int k = 1; k < 6; k++) set_req(k, 5'(8 + k), 4'd0);
        exp_q.push_back({g(4), g(3), g(2), g(1)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL bp_c1 got=%h want=%h", obs, e); end
        n_vec++; if (o_ready !== 6'b011110) begin n_err++; $display("FAIL bp_full_ready got=%b want=011110", o_ready); end
        i_valid = '0;
        set_req(0, 5'd18, 4'd0);
        exp_q.push_back({g(10), g(9), g(16), g(5)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL bp_c2 got=%h want=%h", obs, e); end
        n_vec++; if (o_ready[0] !== 1'b1) begin n_err++; $display("FAIL bp_ready_back got=%b want=1", o_ready[0]); end
        exp_q.push_back({g(17), g(13), g(12), g(11)}); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL bp_c3 got=%h want=%h", obs, e); end
        exp_q.push_back({18'd0, g(18)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL bp_c4 got=%h want=%h", obs, e); end
        exp_q.push_back(24'd0); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e || o_idle !== 1'b1) begin n_err++; $display("FAIL bp_drain got=%h/%b want=%h/1", obs, o_idle, e); end
    endtask

    task automatic test_kill;
        logic [23:0] e;
        do_reset();
        set_req(1, 5'd31, 4'd0);
        exp_q.push_back(24'd0); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL kill_pre_accept got=%h want=%h", obs, e); end
        exp_q.push_back({18'd0, g(31)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL kill_pre_grant got=%h want=%h", obs, e); end
        set_req(1, 5'd20, 4'd3);
        for (int k = 2; k < 6; k++) set_req(k, 5'(k), 4'd6);
        exp_q.push_back(24'd0); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL kill_c0 got=%h want=%h", obs, e); end
        set_req(1, 5'd21, 4'd6);
        exp_q.push_back({g(5), g(4), g(3), g(2)}); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL kill_c1 got=%h want=%h", obs, e); end
        i_kill = {1'b1, 4'd4};
        set_req(3, 5'd22, 4'd5);
        #1;
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL kill_hold_out got=%h want=%h", obs, e); end
        n_vec++; if (o_ready[3] !== 1'b1 || o_ready[1] !== 1'b0) begin n_err++; $display("FAIL kill_ready got=%b want=1,0", {o_ready[3], o_ready[1]}); end
        exp_q.push_back({18'd0, g(20)}); cyc; i_valid = '0; i_kill = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL kill_survivor got=%h want=%h", obs, e); end
        n_vec++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL kill_idle got=%b want=1", o_idle); end
        exp_q.push_back(24'd0); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL kill_removed got=%h want=%h", obs, e); end
    endtask

    task automatic test_wrap_kill;
        logic [23:0] e;
        do_reset();
        set_req(0, 5'd30, 4'd0);
        exp_q.push_back(24'd0); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL wrap_pre_accept got=%h want=%h", obs, e); end
        exp_q.push_back({18'd0, g(30)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL wrap_pre_grant got=%h want=%h", obs, e); end
        set_req(0, 5'd24, 4'd1);
        for (int k = 1; k < 5; k++) set_req(k, 5'(k), 4'd0);
        exp_q.push_back(24'd0); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL wrap_c0 got=%h want=%h", obs, e); end
        set_req(0, 5'd25, 4'd13);
        exp_q.push_back({g(4), g(3), g(2), g(1)}); cyc; i_valid = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL wrap_c1 got=%h want=%h", obs, e); end
        i_kill = {1'b1, 4'd14};
        exp_q.push_back(24'd0); cyc; i_kill = '0; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL wrap_killed_head got=%h want=%h", obs, e); end
        n_vec++; if (o_idle !== 1'b0) begin n_err++; $display("FAIL wrap_tail_kept got=%b want=0", o_idle); end
        exp_q.push_back({18'd0, g(25)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL wrap_survivor got=%h want=%h", obs, e); end
        n_vec++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL wrap_idle got=%b want=1", o_idle); end
    endtask

    task automatic test_reset_mid;
        logic [23:0] e;
        do_reset();
        for (int k = 0; k < 6; k++) set_req(k, 5'(k), 4'd0);
        exp_q.push_back(24'd0); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL rstmid_c0 got=%h want=%h", obs, e); end
        for (int k = 0; k < 6; k++) set_req(k, 5'(8 + k), 4'd0);
        exp_q.push_back({g(3), g(2), g(1), g(0)}); cyc; e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL rstmid_c1 got=%h want=%h", obs, e); end
        n_vec++; if (o_ready !== 6'b001111) begin n_err++; $display("FAIL rstmid_ready_full got=%b want=001111", o_ready); end
        #2;
        i_rst_n = 1'b0;
        i_valid = '0;
        #1;
        n_vec++; if (obs !== 24'd0) begin n_err++; $display("FAIL rstmid_async got=%h want=0", obs); end
        n_vec++; if (o_ready !== 6'h3f || o_idle !== 1'b1) begin n_err++; $display("FAIL rstmid_rdy got=%h/%b want=3f/1", o_ready, o_idle); end
        cyc;
        i_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(24'd0); cyc; e = exp_q.pop_front();
            n_vec++; if (obs !== e || o_idle !== 1'b1) begin n_err++; $display("FAIL rstmid_stale%0d got=%h/%b want=%h/1", c, obs, o_idle, e); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        i_valid  = '0;
        i_tag    = '0;
        i_brmask = '0;
        i_kill   = '0;
        test_reset();
        test_single();
        test_oversub();
        test_backpressure();
        test_kill();
        test_wrap_kill();
        test_reset_mid();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rob_cpl_arb.md
ROB_CPL_ARB -- requirements
Module: rob_cpl_arb

Interface
REQ-001 SHALL have parameter NREQ, default 6, number of completion requesters (execution units).
REQ-002 SHALL have parameter WIDTH_BANK, default 3, ROB row-index width.
REQ-003 SHALL have parameter WIDTH_BRM, default 4, branch-mask tag width.
REQ-004 SHALL have port i_clk  input  1  clock, rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_valid  input  NREQ  per-requester completion valid.
REQ-007 SHALL have port o_ready  output  NREQ  per-requester buffer can accept.
REQ-008 SHALL have port i_tag  input  NREQ*(WIDTH_BANK+2)  per-requester ROB tag {row, bank[1:0]}; requester k at slice k.
REQ-009 SHALL have port i_brmask  input  NREQ*WIDTH_BRM  per-requester branch tag of the completing uop.
REQ-010 SHALL have port i_kill  input  WIDTH_BRM+1  {kill_en, kill_mask}, same encoding as the ROB kill input.
REQ-011 SHALL have ports o_rst_busy0..o_rst_busy3  output  WIDTH_BANK+3 each  {en, row, bank[1:0]}, connected to ROB busy-clear ports 0..3.
REQ-012 SHALL have port o_idle  output  1  all buffers empty.

Function
REQ-013 SHALL hold per requester a 2-entry FIFO of {tag, brmask}; o_ready[k] = (count[k] < 2), combinational from count only.
REQ-014 SHALL enqueue on i_valid[k] & o_ready[k] at the clock edge; enqueued entries become eligible the following cycle (no bypass).
REQ-015 SHALL treat only the FIFO head of each requester as eligible; at most one grant per requester per cycle.
REQ-016 SHALL select, each cycle, up to 4 eligible heads by scanning requesters rr_ptr, rr_ptr+1, ... mod NREQ; the n-th selected drives port n (0..3).
REQ-017 SHALL register port outputs: granted head appears on o_rst_busyN with en=1 the cycle after selection; unused ports output all zeros.
REQ-018 SHALL dequeue granted heads at the selection edge; simultaneous enqueue and dequeue on one requester SHALL keep count unchanged.
REQ-019 SHALL update rr_ptr to (index of last granted requester + 1) mod NREQ when at least one grant occurs; otherwise rr_ptr holds.
REQ-020 SHALL classify an entry as killed when kill_en=1 and ((entry_brmask - kill_mask) mod 2^WIDTH_BRM) lies in [1, 2^(WIDTH_BRM-1)].
REQ-021 SHALL, in a kill cycle, exclude killed entries from selection and remove them at the edge; a surviving tail entry behind a killed head SHALL become head, order preserved.
REQ-022 SHALL drop (not store) an incoming entry accepted in a kill cycle when it is classified killed; handshake still completes.
REQ-023 SHALL not modify registered outputs already presented in a kill cycle.
REQ-024 SHALL drive o_idle = 1 iff every count is 0.
REQ-025 SHALL permit identical tags on multiple ports in one cycle (ROB ORs ports); no deduplication.
REQ-026 SHALL guarantee starvation freedom: any eligible head is granted within ceil(NREQ/4) cycles absent kill.

Reset
REQ-027 SHALL, on i_rst_n low, asynchronously clear all counts, FIFO contents, rr_ptr to 0, and all o_rst_busyN to 0.
REQ-028 SHALL output o_ready all ones and o_idle=1 while and after reset; entries in flight at reset are discarded.

Verification
REQ-029 Single completion: req 2 valid, tag {row=5, bank=1}, one cycle -> o_rst_busy0 = {1,5,1} exactly 2 cycles after accept, other ports 0, o_idle back to 1.
REQ-030 Oversubscription: all 6 requesters valid with one entry each, rr_ptr=0 -> cycle A ports 0..3 carry req 0,1,2,3; next cycle ports 0,1 carry req 4,5; rr_ptr ends 0.
REQ-031 Backpressure: req 0 held valid 3 cycles with no grants possible (other 5 queued ahead) -> o_ready[0]=0 after 2 accepts; third transfer waits; count never exceeds 2.
REQ-032 Kill: req 1 holds brmask 3 then 6; i_kill={1,4} -> brmask-6 entry removed, brmask-3 entry still granted; incoming brmask 5 same cycle dropped.
REQ-033 Wrap kill: WIDTH_BRM=4, kill_mask=14, entry brmask 1 -> killed; entry brmask 13 -> survives.
REQ-034 Reset mid-operation: assert i_rst_n low with 8 entries queued -> all outputs 0 immediately, o_ready=all ones, no stale grant after release.
